// File: rtl/hsi_color_mask.sv
// Classifies an H/S/I pixel stream against run-time windows into a 2-cycle-latency binary mask,
// with optional per-frame hit count / bounding-box statistics (enabled by defining HSI_MASK_STATS_EN).
module hsi_color_mask #(
  parameter int H_DISP = 640,
  parameter int V_DISP = 480,
  localparam int CW = $clog2(H_DISP * V_DISP + 1),
  localparam int XW = $clog2(H_DISP),
  localparam int YW = $clog2(V_DISP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          HSI_hsync,
  input  logic          HSI_vsync,
  input  logic [7:0]    H_data,
  input  logic [7:0]    S_data,
  input  logic [7:0]    I_data,
  input  logic          HSI_de,
  input  logic [7:0]    h_min,
  input  logic [7:0]    h_max,
  input  logic [7:0]    s_min,
  input  logic [7:0]    i_min,
  input  logic [7:0]    i_max,
  output logic          mask_hsync,
  output logic          mask_vsync,
  output logic          mask_de,
  output logic [7:0]    mask_data,
  output logic          stat_valid,
  output logic [CW-1:0] obj_cnt,
  output logic          box_valid,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max
);

  logic       h_ok, s_ok, i_ok;
  logic       hit1_q, de1_q, hs1_q, vs1_q;
  logic       de2_q, hs2_q, vs2_q;
  logic [7:0] data2_q;

  // Hue window may wrap through 0 when h_min > h_max; an inverted intensity window never passes.
  always_comb begin
    h_ok = (h_min <= h_max) ? ((H_data >= h_min) && (H_data <= h_max))
                            : ((H_data >= h_min) || (H_data <= h_max));
    s_ok = (S_data >= s_min);
    i_ok = (I_data >= i_min) && (I_data <= i_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1_q  <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      data2_q <= 8'h00;
    end else begin
      hit1_q  <= h_ok & s_ok & i_ok;
      de1_q   <= HSI_de;
      hs1_q   <= HSI_hsync;
      vs1_q   <= HSI_vsync;
      de2_q   <= de1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      data2_q <= (hit1_q && de1_q) ? 8'hFF : 8'h00;
    end
  end

  assign mask_hsync = hs2_q;
  assign mask_vsync = vs2_q;
  assign mask_de    = de2_q;
  assign mask_data  = data2_q;

`ifdef HSI_MASK_STATS_EN
  localparam logic [XW-1:0] X_LAST = XW'(H_DISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_DISP - 1);

  logic          de_prev_q, vs_prev_q, frame_seen_q, frame_seen_d;
  logic [XW-1:0] x_q, x_d, xmn_q, xmn_d, xmx_q, xmx_d, x_min_q, x_min_d, x_max_q, x_max_d;
  logic [YW-1:0] y_q, y_d, ymn_q, ymn_d, ymx_q, ymx_d, y_min_q, y_min_d, y_max_q, y_max_d;
  logic [CW-1:0] cnt_q, cnt_d, obj_cnt_q, obj_cnt_d;
  logic          stat_valid_q, stat_valid_d, box_valid_q, box_valid_d;
  logic          vs_rise, de_fall, hit2;

  always_comb begin
    vs_rise      = vs2_q & ~vs_prev_q;
    de_fall      = ~de2_q & de_prev_q;
    hit2         = de2_q & data2_q[0];
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    xmn_d        = xmn_q;
    xmx_d        = xmx_q;
    ymn_d        = ymn_q;
    ymx_d        = ymx_q;
    frame_seen_d = frame_seen_q;
    stat_valid_d = 1'b0;
    obj_cnt_d    = obj_cnt_q;
    box_valid_d  = box_valid_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;

    if (de2_q) begin
      if (x_q != X_LAST) x_d = x_q + 1'b1;
    end else if (de_fall) begin
      x_d = '0;
    end

    if (vs_rise) y_d = '0;
    else if (de_fall && (y_q != Y_LAST)) y_d = y_q + 1'b1;

    // Frame close: publish (unless this is the first edge after reset) and restart accumulation.
    if (vs_rise) begin
      frame_seen_d = 1'b1;
      if (frame_seen_q) begin
        stat_valid_d = 1'b1;
        obj_cnt_d    = cnt_q;
        box_valid_d  = (cnt_q != '0);
        x_min_d      = (cnt_q != '0) ? xmn_q : '0;
        x_max_d      = (cnt_q != '0) ? xmx_q : '0;
        y_min_d      = (cnt_q != '0) ? ymn_q : '0;
        y_max_d      = (cnt_q != '0) ? ymx_q : '0;
      end
      cnt_d = '0;
      xmn_d = X_LAST;
      xmx_d = '0;
      ymn_d = Y_LAST;
      ymx_d = '0;
    end else if (hit2) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (x_q < xmn_q) xmn_d = x_q;
      if (x_q > xmx_q) xmx_d = x_q;
      if (y_q < ymn_q) ymn_d = y_q;
      if (y_q > ymx_q) ymx_d = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_seen_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      xmn_q        <= X_LAST;
      xmx_q        <= '0;
      ymn_q        <= Y_LAST;
      ymx_q        <= '0;
      stat_valid_q <= 1'b0;
      obj_cnt_q    <= '0;
      box_valid_q  <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
    end else begin
      de_prev_q    <= de2_q;
      vs_prev_q    <= vs2_q;
      frame_seen_q <= frame_seen_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      xmn_q        <= xmn_d;
      xmx_q        <= xmx_d;
      ymn_q        <= ymn_d;
      ymx_q        <= ymx_d;
      stat_valid_q <= stat_valid_d;
      obj_cnt_q    <= obj_cnt_d;
      box_valid_q  <= box_valid_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
    end
  end

  assign stat_valid = stat_valid_q;
  assign obj_cnt    = obj_cnt_q;
  assign box_valid  = box_valid_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
`else
  assign stat_valid = 1'b0;
  assign obj_cnt    = '0;
  assign box_valid  = 1'b0;
  assign x_min      = '0;
  assign x_max      = '0;
  assign y_min      = '0;
  assign y_max      = '0;
`endif

endmodule
